phase_scheduler: RTL
====================

# phase_scheduler

Tick-driven phase sequencer for the main/side intersection. It latches walk-button, side-sensor and emergency requests and decides the next signal phase and its duration. It drives the light codes, the walk lamp and a seconds-remaining count to the display/segment logic. It sits between the clock divider's 1 Hz enable and the seven-segment refresh block.

## Interface
- TBASE, 6: base green time in ticks; 2*TBASE must be ≤ 15
- TEXT, 3: one-shot side-green extension in ticks
- TYEL, 2: yellow time in ticks
- TWALK, 4: all-red pedestrian phase in ticks
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-clk-wide enable pulse, 1 per second; all timing advances only on tick
- walk_btn  in  1  pedestrian button level
- side_sensor  in  1  side-road vehicle present
- emerg  in  1  emergency vehicle approaching on main road (level)
- phase  out  3  0=G_R 1=Y_R 2=R_G 3=R_Y 4=WALK
- main_light  out  2  0=off 1=green 2=yellow 3=red
- side_light  out  2  same encoding
- walk_light  out  1  high only in WALK
- remaining  out  4  ticks left in current phase, 1..15
- walk_pending  out  1  walk request latched, not yet served

## Operation
- All outputs are registered. main_light, side_light and walk_light are a pure function of phase and update in the same cycle as phase.
- Light pairs per phase:
  - G_R: 1/3
  - Y_R: 2/3
  - R_G: 3/1
  - R_Y: 3/2
  - WALK: 3/3, walk_light=1
- Reset (reset low, async) forces:
  - phase=R_Y, main=3, side=2, walk_light=0
  - remaining=TYEL
  - walk_pending=0, side_req=0, ext_used=0
- Request latches (clock edge, independent of tick):
  - walk_pending: set when walk_btn=1 and phase≠WALK. Cleared on entry to WALK.
  - side_req: set when side_sensor=1 and phase=G_R. Cleared on entry to R_G.
- On each tick, if remaining==1 the phase ends: load next phase and its duration. Otherwise remaining decrements, except where noted below.
- Transitions and durations:
  - R_Y → G_R, load 2*TBASE.
  - G_R → Y_R (load TYEL) at normal end. Early gap-out when side_req=1 and remaining ≤ TBASE+1, which gives minimum green of TBASE ticks.
  - Y_R → WALK (load TWALK) if walk_pending=1. Otherwise → R_G (load TBASE).
  - WALK → R_G, load TBASE.
  - R_G at remaining==1: if side_sensor=1 and ext_used=0, reload TEXT and set ext_used. Otherwise → R_Y (load TYEL). ext_used clears on entry to R_G.
- Emergency (sampled on tick):
  - In G_R with emerg=1: remaining holds; gap-out is suppressed.
  - In R_G with emerg=1: go to R_Y immediately (load TYEL).
  - Y_R, R_Y and WALK are never shortened. Emergency takes effect when the following phase starts.
- Priority on a single tick: emergency > normal end/gap-out > extension.

## Timing
- Phase of duration D spans exactly D ticks. remaining shows D, D-1, …, 1.
- A latch set in cycle n is visible to a tick at cycle n+1 or later. walk_btn high only in the same cycle as the Y_R ending tick is not served in that cycle. It stays pending and is served at the next Y_R.
- tick asserted in the reset-release cycle is ignored.
- Reset asserted mid-phase takes effect immediately, with no clock required. Outputs return to reset values and all latches clear.
- No combinational path from inputs to outputs.
- remaining never reaches 0 and never wraps. Loaded values are ≤ 15 by the parameter constraint.

## Test plan
- Free-run after reset, no requests, 40 ticks: sequence is R_Y(2) → G_R(12) → Y_R(2) → R_G(6) → R_Y(2) → G_R. remaining counts down correctly in each phase.
- side_sensor pulse during the 2nd G_R tick: G_R lasts 6 ticks, then Y_R. side_req clears on entering R_G.
- walk_btn pulse during G_R: walk_pending=1. After Y_R, WALK lasts 4 ticks with lights 3/3 and walk_light=1, then R_G(6). walk_pending drops on WALK entry.
- side_sensor held high through R_G: R_G lasts 6+3=9 ticks, with one extension only, then R_Y.
- emerg raised at R_G tick 2: next tick enters R_Y, then G_R. emerg held during G_R: remaining frozen until emerg drops.
- reset pulsed low mid-WALK with no clk edge: outputs immediately show R_Y, 3/2, walk_light=0, remaining=2, walk_pending=0.

Source files
------------

// File: rtl/phase_scheduler.sv
// rtl/phase_scheduler.sv - tick-driven main/side intersection phase sequencer with walk, gap-out, extension and emergency handling
module phase_scheduler #(
  parameter int TBASE = 6,
  parameter int TEXT  = 3,
  parameter int TYEL  = 2,
  parameter int TWALK = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       walk_btn,
  input  logic       side_sensor,
  input  logic       emerg,
  output logic [2:0] phase,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       walk_light,
  output logic [3:0] remaining,
  output logic       walk_pending
);

  typedef enum logic [2:0] {
    G_R  = 3'd0,
    Y_R  = 3'd1,
    R_G  = 3'd2,
    R_Y  = 3'd3,
    WALK = 3'd4
  } phase_e;

  localparam logic [3:0] LD_GREEN = 4'(2 * TBASE);
  localparam logic [3:0] LD_BASE  = 4'(TBASE);
  localparam logic [3:0] LD_EXT   = 4'(TEXT);
  localparam logic [3:0] LD_YEL   = 4'(TYEL);
  localparam logic [3:0] LD_WALK  = 4'(TWALK);
  localparam logic [3:0] GAP_LIM  = 4'(TBASE + 1);

  phase_e     phase_q, phase_d;
  logic [3:0] rem_q, rem_d;
  logic       wp_q, wp_d;
  logic       side_req_q, side_req_d;
  logic       ext_used_q, ext_used_d;
  logic       run_q;
  logic [1:0] main_q, main_d;
  logic [1:0] side_q, side_d;
  logic       walk_q, walk_d;
  logic       enter_rg, enter_walk;

  always_comb begin
    phase_d    = phase_q;
    rem_d      = rem_q;
    ext_used_d = ext_used_q;

    // run_q masks the tick that may coincide with the first edge after reset release
    if (tick && run_q) begin
      case (phase_q)
        R_Y: begin
          if (rem_q == 4'd1) begin
            phase_d = G_R;
            rem_d   = LD_GREEN;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
        G_R: begin
          if (!emerg) begin
            if (rem_q == 4'd1 || (side_req_q && rem_q <= GAP_LIM)) begin
              phase_d = Y_R;
              rem_d   = LD_YEL;
            end else begin
              rem_d = rem_q - 4'd1;
            end
          end
        end
        Y_R: begin
          if (rem_q == 4'd1) begin
            if (wp_q) begin
              phase_d = WALK;
              rem_d   = LD_WALK;
            end else begin
              phase_d = R_G;
              rem_d   = LD_BASE;
            end
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
        WALK: begin
          if (rem_q == 4'd1) begin
            phase_d = R_G;
            rem_d   = LD_BASE;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
        R_G: begin
          if (emerg) begin
            phase_d = R_Y;
            rem_d   = LD_YEL;
          end else if (rem_q == 4'd1) begin
            if (side_sensor && !ext_used_q) begin
              rem_d      = LD_EXT;
              ext_used_d = 1'b1;
            end else begin
              phase_d = R_Y;
              rem_d   = LD_YEL;
            end
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
        default: begin
          phase_d = R_Y;
          rem_d   = LD_YEL;
        end
      endcase
    end

    enter_rg   = (phase_d == R_G)  && (phase_q != R_G);
    enter_walk = (phase_d == WALK) && (phase_q != WALK);

    if (enter_rg) ext_used_d = 1'b0;
    wp_d       = enter_walk ? 1'b0 : (wp_q | (walk_btn && phase_q != WALK));
    side_req_d = enter_rg ? 1'b0 : (side_req_q | (side_sensor && phase_q == G_R));

    main_d = 2'd3;
    side_d = 2'd3;
    walk_d = 1'b0;
    case (phase_d)
      G_R:     begin main_d = 2'd1; side_d = 2'd3; end
      Y_R:     begin main_d = 2'd2; side_d = 2'd3; end
      R_G:     begin main_d = 2'd3; side_d = 2'd1; end
      R_Y:     begin main_d = 2'd3; side_d = 2'd2; end
      WALK:    begin main_d = 2'd3; side_d = 2'd3; walk_d = 1'b1; end
      default: begin main_d = 2'd3; side_d = 2'd3; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q    <= R_Y;
      rem_q      <= LD_YEL;
      wp_q       <= 1'b0;
      side_req_q <= 1'b0;
      ext_used_q <= 1'b0;
      run_q      <= 1'b0;
      main_q     <= 2'd3;
      side_q     <= 2'd2;
      walk_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      rem_q      <= rem_d;
      wp_q       <= wp_d;
      side_req_q <= side_req_d;
      ext_used_q <= ext_used_d;
      run_q      <= 1'b1;
      main_q     <= main_d;
      side_q     <= side_d;
      walk_q     <= walk_d;
    end
  end

  assign phase        = phase_q;
  assign remaining    = rem_q;
  assign walk_pending = wp_q;
  assign main_light   = main_q;
  assign side_light   = side_q;
  assign walk_light   = walk_q;

endmodule
